serial_pattern_source: RTL and testbench

- Upstream stimulus stage for the 10010 sequence detectors (Moore and Mealy variants).
- Accepts a parallel bit pattern plus a length through a valid/ready load handshake.
- Shifts the pattern out MSB-first, one bit per clock, on the serial line j that drives the detectors' data input.
- Supports one-shot and continuous-repeat modes, abort, and a completion pulse.

---
 rtl/serial_pattern_source_if.sv | 27 ++
 rtl/serial_pattern_source.sv | 100 ++++++++++
 tb/tb_serial_pattern_source.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_source_if.sv
// Load handshake and serial output bundle for serial_pattern_source.
// load_valid/load_ready: a pattern transfers on a rising edge where both are 1; the master may hold or drop valid freely.
interface serial_pattern_source_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic             load_repeat;
  logic             stop;
  logic             j;
  logic             j_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, load_len, load_repeat, stop,
    input  load_ready, j, j_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, load_len, load_repeat, stop,
    output load_ready, j, j_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_source.sv
// Parallel-to-serial pattern source feeding the 10010 sequence detectors.
// Shifts a loaded pattern out MSB-first on j, one-shot or repeating, with abort and a done pulse.
module serial_pattern_source #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_pattern_source_if.slave  bus,
  output logic                    state_dbg
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [LEN_W-1:0] len_q;
  logic             rep_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] eff_len;

  // Bit select through a compare loop keeps the index width independent of WIDTH.
  function automatic logic bit_at(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LEN_W'(i) == idx) b = d[i];
    end
    return b;
  endfunction

  // Zero or oversized lengths fall back to the full pattern width.
  always_comb begin
    eff_len = bus.load_len;
    if (bus.load_len == '0 || bus.load_len > LEN_W'(WIDTH)) eff_len = LEN_W'(WIDTH);
  end

  always_comb begin
    bus.load_ready = (state == IDLE) & ~rst;
    state_dbg      = (state == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.j       <= 1'b0;
      bus.j_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      cnt_q       <= '0;
      data_q      <= '0;
      len_q       <= '0;
      rep_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.load_valid) begin
            data_q      <= bus.load_data;
            len_q       <= eff_len;
            rep_q       <= bus.load_repeat;
            bus.j       <= bit_at(bus.load_data, eff_len - LEN_W'(1));
            bus.j_valid <= 1'b1;
            bus.busy    <= 1'b1;
            cnt_q       <= eff_len - LEN_W'(1);
            state       <= SHIFT;
          end else begin
            bus.j       <= 1'b0;
            bus.j_valid <= 1'b0;
            bus.busy    <= 1'b0;
          end
        end
        SHIFT: begin
          bus.done <= 1'b0;
          if (bus.stop) begin
            // Abort ends silently: no done pulse.
            bus.j       <= 1'b0;
            bus.j_valid <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - LEN_W'(1);
            bus.j <= bit_at(data_q, cnt_q - LEN_W'(1));
          end else if (rep_q) begin
            cnt_q <= len_q - LEN_W'(1);
            bus.j <= bit_at(data_q, len_q - LEN_W'(1));
          end else begin
            bus.j       <= 1'b0;
            bus.j_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_source.sv
// Self-checking bench for serial_pattern_source: queue-based reference model plus directed scenarios.
module tb_serial_pattern_source;

  logic clk;
  logic rst;
  logic state_dbg;

  serial_pattern_source_if #(.WIDTH(16), .LEN_W(5)) bus();

  serial_pattern_source #(.WIDTH(16), .LEN_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The pattern is a queue of bits in send order; the remaining-bits queue drains one per edge.
  bit   m_pat[$];
  bit   m_rem[$];
  logic m_active = 1'b0;
  logic m_rep = 1'b0;
  int   m_len;
  logic exp_j = 1'b0, exp_valid = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

  task automatic m_idle_out();
    exp_j = 1'b0; exp_valid = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic m_show();
    exp_j = m_rem.pop_front(); exp_valid = 1'b1; exp_busy = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_rep = 1'b0; exp_done = 1'b0;
      m_pat.delete(); m_rem.delete();
      m_idle_out();
    end else if (!m_active) begin
      exp_done = 1'b0;
      if (bus.load_valid) begin
        m_len = int'(bus.load_len);
        if (m_len == 0 || m_len > 16) m_len = 16;
        m_pat.delete();
        for (int i = m_len - 1; i >= 0; i--) m_pat.push_back(bus.load_data[i]);
        m_rem = m_pat;
        m_rep = bus.load_repeat;
        m_active = 1'b1;
        m_show();
      end else begin
        m_idle_out();
      end
    end else begin
      exp_done = 1'b0;
      if (bus.stop) begin
        m_active = 1'b0;
        m_idle_out();
      end else if (m_rem.size() > 0) begin
        m_show();
      end else if (m_rep) begin
        m_rem = m_pat;
        m_show();
      end else begin
        m_active = 1'b0;
        m_idle_out();
        exp_done = 1'b1;
      end
    end
  end

  // ---------------- compare process + capture ----------------
  logic [31:0] cap_bits = '0;
  int          cap_n = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("j",          {31'b0, bus.j},          {31'b0, exp_j});
      check("j_valid",    {31'b0, bus.j_valid},    {31'b0, exp_valid});
      check("busy",       {31'b0, bus.busy},       {31'b0, exp_busy});
      check("done",       {31'b0, bus.done},       {31'b0, exp_done});
      check("load_ready", {31'b0, bus.load_ready}, {31'b0, (!m_active && !rst)});
      if (bus.j_valid === 1'b1) begin
        cap_bits = {cap_bits[30:0], bus.j};
        cap_n++;
      end
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_bits = '0; cap_n = 0; done_cnt = 0;
  endtask

  task automatic load(input logic [15:0] d, input logic [4:0] l, input logic r);
    bus.load_data = d; bus.load_len = l; bus.load_repeat = r; bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 64) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, {31'b0, bus.busy}, 32'd0);
    tick();
  endtask

  task automatic run_stop(input int nth);
    for (int i = 1; i < nth; i++) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_len = '0;
    bus.load_repeat = 1'b0; bus.stop = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_ready",  {31'b0, bus.load_ready}, 32'd0);
    check("rst_busy",   {31'b0, bus.busy},       32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_ready", {31'b0, bus.load_ready}, 32'd1);

    // One-shot 10010
    clear_cap();
    load(16'h0012, 5'd5, 1'b0);
    wait_idle("oneshot");
    check("oneshot_n",    cap_n, 32'd5);
    check("oneshot_bits", cap_bits, 32'b10010);
    check("oneshot_done", done_cnt, 32'd1);

    // Repeat 101, stop while the 9th bit is shown
    clear_cap();
    load(16'h0005, 5'd3, 1'b1);
    run_stop(9);
    check("rep9_n",    cap_n, 32'd9);
    check("rep9_bits", cap_bits, 32'b101101101);
    check("rep9_busy", {31'b0, bus.busy}, 32'd0);

    // Repeat 101, stop during the 5th bit
    clear_cap();
    load(16'h0005, 5'd3, 1'b1);
    run_stop(5);
    check("stop_valid", {31'b0, bus.j_valid}, 32'd0);
    check("stop_busy",  {31'b0, bus.busy},    32'd0);
    tick(); tick();
    check("stop_n",    cap_n, 32'd5);
    check("stop_bits", cap_bits, 32'b10110);
    check("stop_done", done_cnt, 32'd0);

    // Stop while idle is ignored
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    check("idle_stop_ready", {31'b0, bus.load_ready}, 32'd1);

    // len=0 -> 16 bits
    clear_cap();
    load(16'h8001, 5'd0, 1'b0);
    wait_idle("len0");
    check("len0_n",    cap_n, 32'd16);
    check("len0_bits", cap_bits, 32'h8001);

    // len=1 -> data[0] only
    clear_cap();
    load(16'h0001, 5'd1, 1'b0);
    wait_idle("len1");
    check("len1_n",    cap_n, 32'd1);
    check("len1_bits", cap_bits, 32'd1);
    check("len1_done", done_cnt, 32'd1);

    // len=20 -> 16 bits
    clear_cap();
    load(16'hA5C3, 5'd20, 1'b0);
    wait_idle("len20");
    check("len20_n",    cap_n, 32'd16);
    check("len20_bits", cap_bits, 32'h0000A5C3);

    // Upper data bits ignored
    clear_cap();
    load(16'hFFF2, 5'd4, 1'b0);
    wait_idle("mask");
    check("mask_bits", cap_bits, 32'b0010);

    // Load while busy ignored
    clear_cap();
    load(16'h0012, 5'd5, 1'b0);
    bus.load_data = 16'hFFFF; bus.load_len = 5'd5; bus.load_valid = 1'b1;
    tick(); tick();
    bus.load_valid = 1'b0;
    wait_idle("busyload");
    check("busyload_bits", cap_bits, 32'b10010);
    check("busyload_n",    cap_n, 32'd5);

    // Back-to-back: B held valid through A's done cycle
    clear_cap();
    load(16'h0012, 5'd5, 1'b0);
    bus.load_data = 16'h000B; bus.load_len = 5'd4; bus.load_repeat = 1'b0; bus.load_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (bus.load_ready !== 1'b1 && n < 64) begin tick(); n++; end
      check("b2b_timeout", {31'b0, bus.load_ready}, 32'd1);
      check("b2b_gap_j",   {31'b0, bus.j},          32'd0);
    end
    tick();
    bus.load_valid = 1'b0;
    wait_idle("b2b");
    check("b2b_n",    cap_n, 32'd9);
    check("b2b_bits", cap_bits, 32'b100101011);
    check("b2b_done", done_cnt, 32'd2);

    // Reset mid-shift on the 3rd bit
    load(16'h0012, 5'd5, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rstmid_j",     {31'b0, bus.j},          32'd0);
    check("rstmid_valid", {31'b0, bus.j_valid},    32'd0);
    check("rstmid_busy",  {31'b0, bus.busy},       32'd0);
    check("rstmid_done",  {31'b0, bus.done},       32'd0);
    check("rstmid_ready", {31'b0, bus.load_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_ready_after", {31'b0, bus.load_ready}, 32'd1);
    tick();
    clear_cap();
    load(16'h0016, 5'd5, 1'b0);
    wait_idle("postrst");
    check("postrst_bits", cap_bits, 32'b10110);
    check("postrst_done", done_cnt, 32'd1);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
